// File: rtl/mult4_arb_pkg.sv
// Shared types and widths for the mult4 arbiter slice.
package mult4_arb_pkg;

  localparam int A_W     = 4;
  localparam int C_W     = 8;
  localparam int MAX_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

endpackage

// File: rtl/mult4.sv
// Combinational 4x4 -> 8-bit unsigned multiplier, the shared datapath.
module mult4
  import mult4_arb_pkg::*;
(
  input  logic [A_W-1:0] a,
  input  logic [A_W-1:0] b,
  output logic [C_W-1:0] c
);

  assign c = C_W'(a) * C_W'(b);

endmodule

// File: rtl/mult4_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 (mod N) upward.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_grant) + i) % N;
      if (!any_grant && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        any_grant   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult4_arbiter.sv
// Shares one mult4 between N_REQ requesters: round-robin accept, multiply, hold result until taken.
module mult4_arbiter
  import mult4_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*A_W-1:0] req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [C_W-1:0]       rsp_c,
  output logic                 busy
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] gnt_idx_p0;
  logic [A_W-1:0]   a_p0;
  logic [A_W-1:0]   b_p0;
  logic [C_W-1:0]   prod;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] arb_idx;
  logic             any_grant;
  logic             accept;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (arb_idx),
    .any_grant (any_grant)
  );

  mult4 u_mult (
    .a(a_p0),
    .b(b_p0),
    .c(prod)
  );

  // rst_n gates req_ready directly so nothing can be accepted while reset is held.
  assign req_ready = (rst_n && state == IDLE && any_grant) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      // Pointing at the last requester makes requester 0 the first candidate.
      last_grant <= IDX_W'(N_REQ - 1);
      gnt_idx_p0 <= '0;
      a_p0       <= '0;
      b_p0       <= '0;
      rsp_c      <= '0;
      rsp_valid  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_p0       <= req_a[int'(arb_idx)*A_W +: A_W];
            b_p0       <= req_b[int'(arb_idx)*A_W +: A_W];
            gnt_idx_p0 <= arb_idx;
            last_grant <= arb_idx;
            state      <= MUL;
          end
        end
        // Stage boundary: captured operands -> registered product.
        MUL: begin
          rsp_c     <= prod;
          rsp_valid <= N_REQ'(1) << gnt_idx_p0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt_idx_p0]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
